aer_event_fifo: RTL

//  Downstream stage of the level-0 pixel-group arbiter. Each cycle the arbiter grants a pixel, this block

---
 rtl/aer_event_fifo.sv | 104 ++++++++++
 1 files changed

// File: rtl/aer_event_fifo.sv
// Address-event capture FIFO: one event per arbiter grant, 1-cycle fall-through to a valid/ready stream.
// Backpressure: registered stall_o at count >= DEPTH-1; events arriving while full and not popping are dropped and counted.
module aer_event_fifo #(
    parameter int GRP_ADD_W  = 2,
    parameter int PIX_ADD_W  = 2,
    parameter int POL_W      = 2,
    parameter int TS_W       = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int DROP_W     = 8,
    localparam int AW        = GRP_ADD_W + PIX_ADD_W,
    localparam int EVT_W     = 2 * AW + POL_W + TS_W,
    localparam int IDX_W     = $clog2(FIFO_DEPTH),
    localparam int PTR_W     = IDX_W + 1
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 active_i,
    input  logic [GRP_ADD_W-1:0] grp_x_i,
    input  logic [GRP_ADD_W-1:0] grp_y_i,
    input  logic [PIX_ADD_W-1:0] pix_x_i,
    input  logic [PIX_ADD_W-1:0] pix_y_i,
    input  logic [POL_W-1:0]     pol_i,
    input  logic                 evt_ready_i,
    output logic                 evt_valid_o,
    output logic [EVT_W-1:0]     evt_data_o,
    output logic                 stall_o,
    output logic [PTR_W-1:0]     fifo_count_o,
    output logic                 ts_wrap_o,
    output logic                 overflow_o,
    output logic [DROP_W-1:0]    drop_cnt_o
);

    logic [TS_W-1:0]   ts_q, ts_d;
    logic              ts_wrap_q, ts_wrap_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  count_d;
    logic              stall_q, stall_d;
    logic              ovf_q, ovf_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic [EVT_W-1:0]  mem_q [FIFO_DEPTH];

    logic             empty, full, pop, push_acc, drop;
    logic [EVT_W-1:0] evt_word;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                      (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
    assign pop      = !empty && evt_ready_i;
    // A full FIFO still takes a new event when the head leaves in the same cycle.
    assign push_acc = active_i && (!full || pop);
    assign drop     = active_i && !push_acc;
    assign evt_word = {grp_x_i, pix_x_i, grp_y_i, pix_y_i, pol_i, ts_q};

    always_comb begin
        ts_d      = ts_q + TS_W'(1);
        ts_wrap_d = (ts_q == {TS_W{1'b1}});
        wr_ptr_d  = push_acc ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d  = pop      ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d   = wr_ptr_d - rd_ptr_d;
        stall_d   = (count_d >= PTR_W'(FIFO_DEPTH - 1));
        ovf_d     = ovf_q | drop;
        drop_d    = drop_q;
        if (drop && (drop_q != {DROP_W{1'b1}})) begin
            drop_d = drop_q + DROP_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ts_q      <= '0;
            ts_wrap_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            stall_q   <= 1'b0;
            ovf_q     <= 1'b0;
            drop_q    <= '0;
        end else begin
            ts_q      <= ts_d;
            ts_wrap_q <= ts_wrap_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            stall_q   <= stall_d;
            ovf_q     <= ovf_d;
            drop_q    <= drop_d;
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk_i) begin
        if (push_acc && !reset_i) begin
            mem_q[wr_ptr_q[IDX_W-1:0]] <= evt_word;
        end
    end

    assign evt_valid_o  = !empty;
    assign evt_data_o   = empty ? '0 : mem_q[rd_ptr_q[IDX_W-1:0]];
    assign stall_o      = stall_q;
    assign fifo_count_o = wr_ptr_q - rd_ptr_q;
    assign ts_wrap_o    = ts_wrap_q;
    assign overflow_o   = ovf_q;
    assign drop_cnt_o   = drop_q;

endmodule
